// File: rtl/pe_ec_ctrl.sv
// pe_ec_ctrl: sequences one binarized conv/pool layer through a single PE.
// For every filter f and pooled pixel (r,c) it requests a window (and the
// filter weights on the filter's first pixel), waits one evaluation cycle,
// captures the PE result and holds it on out_* until the sink accepts it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, busy, done layer start pulse, layer in progress, end-of-layer pulse
//   win_req/row/col   window fetch request and pooled coordinates
//   win_valid         window present on PE data_in
//   w_req, w_idx      weight fetch request and filter index
//   w_valid           weights present on PE weight_in
//   pe_data/pe_pindex PE binarized output and pooling index
//   out_valid/ready   result handshake; out_addr/data/pindex result payload
//   stall_cnt         cycles spent in WRITE with out_ready low
// Optional feature: define PE_EC_CTRL_STALL_CNT_EN to build the stall
// counter; otherwise stall_cnt is tied to zero.
module pe_ec_ctrl #(
    parameter int OUT_H        = 4,
    parameter int OUT_W        = 4,
    parameter int N_FILTER     = 8,
    parameter int PINDEX_WIDTH = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    win_req,
    output logic [$clog2(OUT_H)-1:0]                win_row,
    output logic [$clog2(OUT_W)-1:0]                win_col,
    input  logic                                    win_valid,
    output logic                                    w_req,
    output logic [$clog2(N_FILTER)-1:0]             w_idx,
    input  logic                                    w_valid,
    input  logic                                    pe_data,
    input  logic [PINDEX_WIDTH-1:0]                 pe_pindex,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(OUT_H*OUT_W*N_FILTER)-1:0] out_addr,
    output logic                                    out_data,
    output logic [PINDEX_WIDTH-1:0]                 out_pindex,
    output logic [15:0]                             stall_cnt
);

    localparam int AW = $clog2(OUT_H*OUT_W*N_FILTER);
    localparam int RW = $clog2(OUT_H);
    localparam int CW = $clog2(OUT_W);
    localparam int FW = $clog2(N_FILTER);

    localparam logic [RW-1:0] R_MAX = RW'(OUT_H - 1);
    localparam logic [CW-1:0] C_MAX = CW'(OUT_W - 1);
    localparam logic [FW-1:0] F_MAX = FW'(N_FILTER - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           f_q, f_d;
    logic [RW-1:0]           r_q, r_d;
    logic [CW-1:0]           c_q, c_d;
    logic                    data_q, data_d;
    logic [PINDEX_WIDTH-1:0] pidx_q, pidx_d;

    logic first_px;
    logic last_c;
    logic last_r;
    logic last_f;

    assign first_px = (r_q == '0) && (c_q == '0);
    assign last_c   = (c_q == C_MAX);
    assign last_r   = (r_q == R_MAX);
    assign last_f   = (f_q == F_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            data_q  <= 1'b0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            data_q  <= data_d;
            pidx_q  <= pidx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        r_d       = r_q;
        c_d       = c_q;
        data_d    = data_q;
        pidx_d    = pidx_q;
        win_req   = 1'b0;
        w_req     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    f_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            FETCH: begin
                win_req = 1'b1;
                // weights stay loaded in the PE for the rest of the filter
                w_req   = first_px;
                if (win_valid && (w_valid || !first_px)) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                data_d  = pe_data;
                pidx_d  = pe_pindex;
                state_d = WRITE;
            end
            WRITE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = FETCH;
                    if (last_c) begin
                        c_d = '0;
                        if (last_r) begin
                            r_d = '0;
                            if (last_f) begin
                                f_d     = '0;
                                state_d = DONE;
                            end else begin
                                f_d = f_q + FW'(1);
                            end
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign win_row    = r_q;
    assign win_col    = c_q;
    assign w_idx      = f_q;
    assign out_data   = data_q;
    assign out_pindex = pidx_q;
    assign out_addr   = AW'(32'(f_q) * (OUT_H * OUT_W)
                          + 32'(r_q) * OUT_W
                          + 32'(c_q));

`ifdef PE_EC_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == WRITE && !out_ready
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pe_ec_ctrl.sv
// tb_pe_ec_ctrl: scoreboard bench for pe_ec_ctrl on a 2x2x2 layer.
// Results are predicted as the linear pixel sequence with PE values chosen
// by the bench at each accepted fetch.
module tb_pe_ec_ctrl;

    localparam int H   = 2;
    localparam int W   = 2;
    localparam int F   = 2;
    localparam int PW  = 2;
    localparam int TOT = H * W * F;
    localparam int AW  = $clog2(TOT);

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     win_req;
    logic [$clog2(H)-1:0]     win_row;
    logic [$clog2(W)-1:0]     win_col;
    logic                     win_valid;
    logic                     w_req;
    logic [$clog2(F)-1:0]     w_idx;
    logic                     w_valid;
    logic                     pe_data;
    logic [PW-1:0]            pe_pindex;
    logic                     out_valid;
    logic                     out_ready;
    logic [AW-1:0]            out_addr;
    logic                     out_data;
    logic [PW-1:0]            out_pindex;
    logic [15:0]              stall_cnt;

    pe_ec_ctrl #(
        .OUT_H(H),
        .OUT_W(W),
        .N_FILTER(F),
        .PINDEX_WIDTH(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .win_req(win_req),
        .win_row(win_row),
        .win_col(win_col),
        .win_valid(win_valid),
        .w_req(w_req),
        .w_idx(w_idx),
        .w_valid(w_valid),
        .pe_data(pe_data),
        .pe_pindex(pe_pindex),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_pindex(out_pindex),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          d;
        logic [PW-1:0] p;
    } exp_t;

    exp_t sb[$];
    int   k;
    int   n_chk = 0;
    int   n_err = 0;
    int   cnt = 0;
    int   done_n = 0;
    int   done_at = 0;
    int   win_n = 0;
    int   wr_n = 0;
    int   widx[$];
    logic force_pe = 1'b0;
    logic hs;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // fetch accepted at the coming edge: the PE result appears next cycle
    always @(negedge clk)
        hs = !rst && win_req && win_valid && (w_valid || !w_req);

    initial begin
        k = 0;
        pe_data = 1'b0;
        pe_pindex = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                k = 0;
            end else begin
                #1;
                if (hs) begin
                    pe_data   = force_pe ? 1'b1 : 1'($urandom_range(0, 1));
                    pe_pindex = force_pe ? PW'(2) : PW'($urandom_range(0, 3));
                    sb.push_back('{a: AW'(k % TOT), d: pe_data, p: pe_pindex});
                    k++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_n++;
                done_at = cnt;
            end
            if (win_req) win_n++;
            if (w_req) widx.push_back(int'(w_idx));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_write", 32'(out_addr), 32'hFFFF);
                end else begin
                    chk("out_addr", 32'(out_addr), 32'(sb[0].a));
                    chk("out_data", 32'(out_data), 32'(sb[0].d));
                    chk("out_pindex", 32'(out_pindex), 32'(sb[0].p));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        wr_n++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int s_at);
        start = 1'b1;
        s_at  = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int t = 0;
        while (done_n == d0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (done_n == d0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string nm, input int wrs);
        int t = 0;
        @(negedge clk);
        while (!(out_valid && wr_n == wrs) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!(out_valid && wr_n == wrs)) chk({nm, "_timeout"}, 0, 1);
    endtask

    int s_at, d0, wi0, wl0, wr0, exp_stall, t;
    logic [$clog2(H)-1:0] rr;
    logic [$clog2(W)-1:0] cc;
    logic [AW-1:0] a0;
    logic dd0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        win_valid = 1'b0;
        w_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_win_req", 32'(win_req), 0);
        chk("rst_w_req", 32'(w_req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_win_row", 32'(win_row), 0);
        chk("rst_win_col", 32'(win_col), 0);
        chk("rst_w_idx", 32'(w_idx), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_pindex", 32'(out_pindex), 0);
        tick();
        rst = 1'b0;

        // full-rate layer
        win_valid = 1'b1;
        w_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        d0 = done_n; wi0 = win_n; wl0 = widx.size(); wr0 = wr_n;
        pulse_start(s_at);
        chk("busy_after_start", 32'(busy), 1);
        wait_done("t1", d0);
        chk("done_latency", 32'(done_at - s_at), 25);
        repeat (5) tick();
        chk("done_once", 32'(done_n - d0), 1);
        chk("busy_idle", 32'(busy), 0);
        chk("win_req_cnt", 32'(win_n - wi0), 8);
        chk("w_req_cnt", 32'(widx.size() - wl0), 2);
        if (widx.size() >= wl0 + 2) begin
            chk("w_idx_first", 32'(widx[wl0]), 0);
            chk("w_idx_second", 32'(widx[wl0 + 1]), 1);
        end
        chk("t1_writes", 32'(wr_n - wr0), 8);
        chk("t1_sb_drained", 32'(sb.size()), 0);

        // backpressure on the first write
        out_ready = 1'b0;
        d0 = done_n;
        pulse_start(s_at);
        wait_valid("t2", wr_n);
        a0 = out_addr;
        dd0 = out_data;
        chk("stall_first_addr", 32'(a0), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_valid_held", 32'(out_valid), 1);
        chk("stall_addr_stable", 32'(out_addr), 32'(a0));
        chk("stall_data_stable", 32'(out_data), 32'(dd0));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
`ifdef PE_EC_CTRL_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        wait_done("t2", d0);

        // window not ready for four cycles, forced PE result
        tick();
        win_valid = 1'b0;
        force_pe = 1'b1;
        d0 = done_n;
        pulse_start(s_at);
        t = 0;
        @(negedge clk);
        while (!win_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        rr = win_row;
        cc = win_col;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("fetch_hold", 32'(win_req), 1);
            chk("fetch_row", 32'(win_row), 32'(rr));
            chk("fetch_col", 32'(win_col), 32'(cc));
            chk("fetch_no_valid", 32'(out_valid), 0);
        end
        tick();
        win_valid = 1'b1;
        wait_valid("t3", wr_n);
        chk("forced_data", 32'(out_data), 1);
        chk("forced_pindex", 32'(out_pindex), 2);
        wait_done("t3", d0);
        tick();
        force_pe = 1'b0;

        // start during a layer is ignored
        d0 = done_n; wr0 = wr_n;
        pulse_start(s_at);
        wait_valid("t4", wr0 + 2);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4", d0);
        repeat (8) tick();
        chk("ignored_start_writes", 32'(wr_n - wr0), 8);
        chk("ignored_start_dones", 32'(done_n - d0), 1);
        chk("ignored_start_busy", 32'(busy), 0);

        // reset mid-layer
        wr0 = wr_n;
        pulse_start(s_at);
        wait_valid("t5", wr0 + 4);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_win_req", 32'(win_req), 0);
        tick();
        rst = 1'b0;
        tick();
        d0 = done_n;
        pulse_start(s_at);
        wait_valid("t5b", wr_n);
        chk("restart_addr", 32'(out_addr), 0);
        wait_done("t5b", d0);
        repeat (3) tick();
        chk("restart_sb_drained", 32'(sb.size()), 0);

        // random handshakes, random start pulses
        d0 = done_n;
        t = 0;
        while (done_n - d0 < 3 && t < 4000) begin
            win_valid = ($urandom_range(0, 3) != 0);
            w_valid   = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            tick();
            t++;
        end
        start = 1'b0;
        win_valid = 1'b1;
        w_valid = 1'b1;
        out_ready = 1'b1;
        chk("rand_layers", 32'(done_n - d0), 3);
        repeat (5) tick();
        chk("rand_idle", 32'(busy), 0);
        chk("rand_sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
